// File: rtl/alu_ctrl_if.sv
// Bundle of the request, command and counter signals of the ALU control stage.
// The slave view belongs to the stage itself; the master view belongs to
// whatever drives requests and consumes commands.
interface alu_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [5:0]       funct;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       ALUCtl;
    logic [31:0]      ALU_A;
    logic [31:0]      ALU_B;
    logic             illegal;
    logic [CNT_W-1:0] issue_cnt;

    modport slave (
        input  in_valid, ALUOp, funct, op_a, op_b, out_ready,
        output in_ready, out_valid, ALUCtl, ALU_A, ALU_B, illegal, issue_cnt
    );

    modport master (
        output in_valid, ALUOp, funct, op_a, op_b, out_ready,
        input  in_ready, out_valid, ALUCtl, ALU_A, ALU_B, illegal, issue_cnt
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decodes {ALUOp, funct} into a 4-bit ALU control code,
// then buffers the decoded command with its operands in a two-entry elastic
// buffer (main register M driving the outputs, skid register S behind it).
// in_ready is registered and depends only on S occupancy, so no combinational
// path exists from out_ready to in_ready.
module alu_ctrl_stage #(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    alu_ctrl_if.slave bus
);

    typedef struct packed {
        logic [3:0]  ctl;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    // Returns {ALUCtl, illegal}; unsupported encodings decode to 0000 with illegal set.
    function automatic logic [4:0] decode_fn(input logic [1:0] alu_op, input logic [5:0] fn);
        logic [4:0] res;
        res = {4'b0000, 1'b1};
        case (alu_op)
            2'b00: res = {4'b0010, 1'b0};
            2'b01: res = {4'b0110, 1'b0};
            2'b10: begin
                case (fn)
                    6'b100000: res = {4'b0010, 1'b0};
                    6'b100010: res = {4'b0110, 1'b0};
                    6'b100100: res = {4'b0000, 1'b0};
                    6'b100101: res = {4'b0001, 1'b0};
                    6'b101010: res = {4'b0111, 1'b0};
                    6'b100111: res = {4'b1100, 1'b0};
                    default:   res = {4'b0000, 1'b1};
                endcase
            end
            default: res = {4'b0000, 1'b1};
        endcase
        return res;
    endfunction

    logic [4:0]       dec_s;
    entry_t           in_entry_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    entry_t           m_r;
    logic             m_valid_r;
    entry_t           s_r;
    logic             s_valid_r;
    logic             in_ready_r;
    logic [CNT_W-1:0] cnt_r;

    entry_t           m_nxt_s;
    logic             m_valid_nxt_s;
    entry_t           s_nxt_s;
    logic             s_valid_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    assign dec_s      = decode_fn(bus.ALUOp, bus.funct);
    assign in_entry_s = {dec_s[4:1], dec_s[0], bus.op_a, bus.op_b};
    assign in_xfer_s  = bus.in_valid & in_ready_r;
    assign out_xfer_s = m_valid_r & bus.out_ready;

    // Next-state of the M/S buffer: refill M when it is empty or draining, otherwise park new input in S.
    always_comb begin
        m_nxt_s       = m_r;
        m_valid_nxt_s = m_valid_r;
        s_nxt_s       = s_r;
        s_valid_nxt_s = s_valid_r;
        if (!m_valid_r || out_xfer_s) begin
            if (s_valid_r) begin
                m_nxt_s       = s_r;
                m_valid_nxt_s = 1'b1;
                if (in_xfer_s) begin
                    s_nxt_s       = in_entry_s;
                    s_valid_nxt_s = 1'b1;
                end else begin
                    s_valid_nxt_s = 1'b0;
                end
            end else if (in_xfer_s) begin
                m_nxt_s       = in_entry_s;
                m_valid_nxt_s = 1'b1;
            end else begin
                m_valid_nxt_s = 1'b0;
            end
        end else begin
            if (in_xfer_s) begin
                s_nxt_s       = in_entry_s;
                s_valid_nxt_s = 1'b1;
            end else begin
                s_valid_nxt_s = s_valid_r;
            end
        end
    end

    // Issued-command counter advances on every accepted output, wrapping naturally.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (out_xfer_s) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers; reset empties both slots and wins over any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r        <= '0;
            m_valid_r  <= 1'b0;
            s_r        <= '0;
            s_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
            cnt_r      <= '0;
        end else begin
            m_r        <= m_nxt_s;
            m_valid_r  <= m_valid_nxt_s;
            s_r        <= s_nxt_s;
            s_valid_r  <= s_valid_nxt_s;
            in_ready_r <= ~s_valid_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = m_valid_r;
    assign bus.ALUCtl    = m_r.ctl;
    assign bus.illegal   = m_r.ill;
    assign bus.ALU_A     = m_r.a;
    assign bus.ALU_B     = m_r.b;
    assign bus.issue_cnt = cnt_r;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: two instances (CNT_W=16 and CNT_W=4) share one
// stimulus; a queue model of the stored commands is checked every cycle and
// directed scenarios add literal expectations.
module tb_alu_ctrl_stage;

    typedef struct packed {
        logic [3:0]  ctl;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_ready;

    int          tests = 0;
    int          fails = 0;
    bit          started = 1'b0;
    exp_t        q[$];
    int unsigned mcnt = 0;
    logic [3:0]  rtab [logic [5:0]];
    logic [5:0]  flist [6];

    always #5 clk = ~clk;

    alu_ctrl_if #(.CNT_W(16)) bus16 ();
    alu_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus16.in_valid  = in_valid;
    assign bus16.ALUOp     = alu_op;
    assign bus16.funct     = funct;
    assign bus16.op_a      = op_a;
    assign bus16.op_b      = op_b;
    assign bus16.out_ready = out_ready;
    assign bus4.in_valid   = in_valid;
    assign bus4.ALUOp      = alu_op;
    assign bus4.funct      = funct;
    assign bus4.op_a       = op_a;
    assign bus4.op_b       = op_b;
    assign bus4.out_ready  = out_ready;

    alu_ctrl_stage #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    alu_ctrl_stage #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_entry(input logic [1:0] op, input logic [5:0] f,
                                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.ill = 1'b0;
        if (op == 2'd0) e.ctl = 4'd2;
        else if (op == 2'd1) e.ctl = 4'd6;
        else if (op == 2'd2 && rtab.exists(f)) e.ctl = rtab[f];
        else begin
            e.ctl = 4'd0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Model: queue holds every accepted, not yet issued command (at most two).
    always @(posedge clk) begin
        bit acc;
        bit drn;
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) begin
                void'(q.pop_front());
                mcnt++;
            end
            if (acc) q.push_back(model_entry(alu_op, funct, op_a, op_b));
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (started) begin
            logic [31:0] c32;
            c32 = mcnt;
            chk("out_valid16", bus16.out_valid, q.size() > 0);
            chk("in_ready16", bus16.in_ready, q.size() < 2);
            chk("out_valid4", bus4.out_valid, q.size() > 0);
            chk("in_ready4", bus4.in_ready, q.size() < 2);
            chk("issue_cnt16", bus16.issue_cnt, c32[15:0]);
            chk("issue_cnt4", bus4.issue_cnt, c32[3:0]);
            if (q.size() > 0) begin
                chk("ALUCtl", bus16.ALUCtl, q[0].ctl);
                chk("illegal", bus16.illegal, q[0].ill);
                chk("ALU_A", bus16.ALU_A, q[0].a);
                chk("ALU_B", bus16.ALU_B, q[0].b);
                chk("ALUCtl4", bus4.ALUCtl, q[0].ctl);
                chk("ALU_A4", bus4.ALU_A, q[0].a);
            end
        end
    end

    initial begin
        rtab[6'b100000] = 4'b0010;
        rtab[6'b100010] = 4'b0110;
        rtab[6'b100100] = 4'b0000;
        rtab[6'b100101] = 4'b0001;
        rtab[6'b101010] = 4'b0111;
        rtab[6'b100111] = 4'b1100;
        flist = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

        rst = 1'b1; in_valid = 1'b0; alu_op = 2'd0; funct = 6'd0;
        op_a = 32'd0; op_b = 32'd0; out_ready = 1'b0;
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", bus16.out_valid, 1'b0);
        chk("rst_in_ready", bus16.in_ready, 1'b1);
        chk("rst_ALUCtl", bus16.ALUCtl, 4'b0000);
        chk("rst_ALU_A", bus16.ALU_A, 32'd0);
        chk("rst_ALU_B", bus16.ALU_B, 32'd0);
        chk("rst_illegal", bus16.illegal, 1'b0);
        chk("rst_cnt", bus16.issue_cnt, 16'd0);

        // Single slt command, one-cycle latency.
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b101010;
        op_a = 32'd5; op_b = 32'd9; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("slt_valid", bus16.out_valid, 1'b1);
        chk("slt_ctl", bus16.ALUCtl, 4'b0111);
        chk("slt_a", bus16.ALU_A, 32'd5);
        chk("slt_b", bus16.ALU_B, 32'd9);
        chk("slt_ill", bus16.illegal, 1'b0);
        tick();
        chk("slt_cnt", bus16.issue_cnt, 16'd1);
        chk("slt_drained", bus16.out_valid, 1'b0);

        // Backpressure: two accepted, third waits.
        out_ready = 1'b0; in_valid = 1'b1;
        alu_op = 2'b00; op_a = 32'h11; op_b = 32'h12;
        tick();
        alu_op = 2'b01; op_a = 32'h21; op_b = 32'h22;
        tick();
        chk("bp_ready_low", bus16.in_ready, 1'b0);
        alu_op = 2'b10; funct = 6'b100111; op_a = 32'h31; op_b = 32'h32;
        tick();
        chk("bp_ready_low2", bus16.in_ready, 1'b0);
        chk("bp_hold_ctl", bus16.ALUCtl, 4'b0010);
        tick();
        chk("bp_hold_a", bus16.ALU_A, 32'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_second_ctl", bus16.ALUCtl, 4'b0110);
        chk("bp_ready_back", bus16.in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_third_ctl", bus16.ALUCtl, 4'b1100);
        chk("bp_third_a", bus16.ALU_A, 32'h31);
        tick();
        chk("bp_cnt", bus16.issue_cnt, 16'd4);

        // Illegal encodings are issued, not dropped.
        in_valid = 1'b1; alu_op = 2'b11; funct = 6'b100000; op_a = 32'd41; op_b = 32'd42;
        tick();
        chk("ill11_ctl", bus16.ALUCtl, 4'b0000);
        chk("ill11_flag", bus16.illegal, 1'b1);
        alu_op = 2'b10; funct = 6'b000000; op_a = 32'd51; op_b = 32'd52;
        tick();
        in_valid = 1'b0;
        chk("illf_ctl", bus16.ALUCtl, 4'b0000);
        chk("illf_flag", bus16.illegal, 1'b1);
        chk("illf_a", bus16.ALU_A, 32'd51);
        tick();
        chk("ill_cnt", bus16.issue_cnt, 16'd6);

        // Continuous stream of 100 from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            alu_op = 2'(i % 3);
            funct = flist[i % 6];
            op_a = 32'(i * 3);
            op_b = ~32'(i);
            tick();
            chk("stream_ready", bus16.in_ready, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_cnt16", bus16.issue_cnt, 16'd100);
        chk("stream_cnt4", bus4.issue_cnt, 4'd4);

        // Counter wrap on the narrow instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            in_valid = 1'b1; alu_op = 2'b01; op_a = 32'(i); op_b = 32'(i + 100);
            tick();
            if (i == 16) chk("wrap_15", bus4.issue_cnt, 4'd15);
            if (i == 17) chk("wrap_0", bus4.issue_cnt, 4'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_1", bus4.issue_cnt, 4'd1);

        // Reset while both slots are full.
        out_ready = 1'b0; in_valid = 1'b1; alu_op = 2'b00; op_a = 32'hA1; op_b = 32'hA2;
        tick();
        op_a = 32'hB1; op_b = 32'hB2;
        tick();
        in_valid = 1'b0;
        chk("full_ready", bus16.in_ready, 1'b0);
        chk("full_valid", bus16.out_valid, 1'b1);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op_a = 32'hC1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst_valid", bus16.out_valid, 1'b0);
        chk("mrst_ready", bus16.in_ready, 1'b1);
        chk("mrst_cnt", bus16.issue_cnt, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_no_stale", bus16.out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 Parameter: CNT_W, 16, width of issued-operation counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  stage can accept a request this cycle.
REQ-006 ALUOp  input  2  main-control operation class.
REQ-007 funct  input  6  R-type function field.
REQ-008 op_a  input  32  first operand.
REQ-009 op_b  input  32  second operand.
REQ-010 out_valid  output  1  ALU command valid.
REQ-011 out_ready  input  1  ALU consumer accepts command.
REQ-012 ALUCtl  output  4  decoded ALU control code.
REQ-013 ALU_A  output  32  registered first operand.
REQ-014 ALU_B  output  32  registered second operand.
REQ-015 illegal  output  1  decoded request had unsupported ALUOp/funct.
REQ-016 issue_cnt  output  CNT_W  count of commands accepted by consumer.

Function
REQ-017 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Decode, ALUOp 00: ALUCtl=0010 (add), illegal=0, funct ignored.
REQ-019 Decode, ALUOp 01: ALUCtl=0110 (sub), illegal=0, funct ignored.
REQ-020 Decode, ALUOp 10 by funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100; illegal=0.
REQ-021 ALUOp 10 with any other funct, or ALUOp 11: ALUCtl=0000, illegal=1; entry still issued, not dropped.
REQ-022 Decode occurs before storage; stored entry = {ALUCtl, illegal, op_a, op_b}.
REQ-023 Storage: output register M plus one skid register S; capacity 2 entries.
REQ-024 in_ready SHALL be a registered signal equal to NOT S-occupied; no combinational path out_ready->in_ready.
REQ-025 Outputs out_valid/ALUCtl/ALU_A/ALU_B/illegal come directly from M.
REQ-026 When M empty or M draining (output transfer): M loads S if S occupied, else loads the input entry on input transfer, else M becomes empty.
REQ-027 When M occupied, not draining, and input transfer occurs: entry written to S.
REQ-028 When S moves into M and an input transfer occurs same cycle, input entry is written to S.
REQ-029 Latency: input accepted in cycle N appears on outputs in cycle N+1 when M empty or draining.
REQ-030 Throughput: with out_ready held high, one command per cycle, in_ready stays 1.
REQ-031 Order: commands leave in acceptance order; none lost or duplicated.
REQ-032 While out_valid=1 and out_ready=0, M contents SHALL remain stable.
REQ-033 issue_cnt increments by 1 on each output transfer, wraps 2^CNT_W-1 -> 0.
REQ-034 Illegal commands count in issue_cnt like legal ones.

Reset
REQ-035 On rst=1 at a clock edge: M and S empty, out_valid=0, in_ready=1, ALUCtl=0000, ALU_A=0, ALU_B=0, illegal=0, issue_cnt=0.
REQ-036 rst mid-operation discards both stored entries; transfers in the reset cycle are ignored.
REQ-037 rst has priority over all other updates.

Verification
REQ-038 Reset then ALUOp=10, funct=101010, op_a=5, op_b=9, out_ready=1 -> next cycle out_valid=1, ALUCtl=0111, ALU_A=5, ALU_B=9, illegal=0, then issue_cnt=1.
REQ-039 out_ready=0, three back-to-back requests (ALUOp 00,01,10/100111) -> first two accepted, in_ready=0 from cycle after second; raise out_ready -> outputs 0010,0110, then third accepted and issued as 1100.
REQ-040 ALUOp=11 and ALUOp=10/funct=000000 -> ALUCtl=0000, illegal=1 each, both issued, issue_cnt advances by 2.
REQ-041 Continuous stream of 100 requests, out_ready=1 -> 100 ordered outputs, in_ready never 0, issue_cnt=100.
REQ-042 CNT_W=4, 17 issued commands -> issue_cnt sequence reaches 15 then wraps to 0, ends at 1.
REQ-043 Two entries held (out_ready=0), assert rst one cycle -> out_valid=0, in_ready=1, issue_cnt=0; no stale entry emerges afterwards.
